echo_request_arbiter: RTL and testbench
=======================================

# echo_request_arbiter

Round-robin arbiter that shares one Echo request/indication pair among NREQ independent requesters. Forwards one requester's say call per cycle into the Echo say port and records the issuer in a tag FIFO. Routes each returning heard indication to the requester that issued it, in order. Sits between the software-facing request ports and a single Echo instance.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8, power of two); TW = log2(NREQ)
- DEPTH, 4, tag FIFO depth = max in-flight requests (power of two, ≥2)

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, synchronous, active-low
- req$say__ENA  input  NREQ  per-requester call request
- req$say_meth  input  32*NREQ  requester i at bits [32i+31:32i]
- req$say_v  input  32*NREQ  same packing
- req$say__RDY  output  NREQ  per-requester accept
- ind$heard__ENA  output  NREQ  one-hot response delivery
- ind$heard_meth  output  32  shared response payload
- ind$heard_v  output  32  shared response payload
- ind$heard__RDY  input  NREQ  per-requester response ready
- echo$say__ENA  output  1  forwarded call
- echo$say_meth  output  32  forwarded payload
- echo$say_v  output  32  forwarded payload
- echo$say__RDY  input  1  Echo accepts
- echo$heard__ENA  input  1  Echo response valid
- echo$heard_meth  input  32  response payload
- echo$heard_v  input  32  response payload
- echo$heard__RDY  output  1  arbiter accepts response
- inflight  output  log2(DEPTH)+1  tag FIFO occupancy

## Operation

- State: grant pointer ptr[TW-1:0]; tag FIFO of DEPTH×TW entries, rd/wr pointers log2(DEPTH) bits wrapping modulo DEPTH; count log2(DEPTH)+1 bits.
- ENA without RDY is legal and means "pending"; a transfer happens only when ENA && RDY.
- req$say__RDY[i] = (i == ptr) && echo$say__RDY && (count != DEPTH). RDY never depends on any ENA.
- fire = req$say__ENA[ptr] && req$say__RDY[ptr]. echo$say__ENA = fire; echo$say_meth/v = slice ptr of req buses (driven regardless of fire).
- On fire: push ptr at wr, wr++.
- Grant update each cycle: if req$say__ENA[ptr] && !fire, ptr holds. Otherwise ptr ← first index in cyclic order ptr+1, ptr+2, …, ptr+NREQ (ptr last) with ENA asserted; if none asserted, ptr holds.
- Response: head = FIFO[rd]. echo$heard__RDY = (count != 0) && ind$heard__RDY[head].
- ind$heard__ENA = onehot(head) when echo$heard__ENA && echo$heard__RDY, else 0. ind$heard_meth/v pass through from echo$heard_meth/v.
- On delivery: rd++.
- count: +1 on push only, −1 on pop only, unchanged on both or neither. inflight = count.
- Full (count == DEPTH): all say RDY low; pop in that cycle frees a slot for the next cycle only.
- Empty: echo$heard__RDY low, so a response cannot bypass a same-cycle push.
- Echo responses return in issue order, so the FIFO head always matches the next response.

## Timing

- Reset (nRST low at posedge): ptr=0, rd=wr=0, count=0. Outputs after reset: all ind$heard__ENA=0, echo$say__ENA=0, echo$heard__RDY=0, inflight=0; req$say__RDY = {0…, echo$say__RDY} (bit 0 only).
- Reset mid-operation discards all tags. The Echo instance shares nRST, so it cannot return orphan responses.
- Issue latency: 0 cycles when the requester already holds the grant; otherwise 1 cycle of grant move after it raises ENA, provided no other requester is blocked at ptr.
- Max wait for a continuously requesting requester: NREQ−1 other transfers.
- Response routing is combinational: delivery happens in the same cycle as echo$heard__ENA.
- Throughput: one issue and one delivery per cycle, limited by Echo.

## Test plan

- Reset, then requester 0 calls with meth=1, v=0x10 while Echo ready -> echo$say__ENA=1 same cycle, inflight=1; heard returns -> ind$heard__ENA=4'b0001 with v=0x10, inflight=0.
- All four ENA held high, Echo always ready -> grant order 0,1,2,3,0 on consecutive transfers; no requester is skipped.
- Requester 2 alone raises ENA with ptr=0 -> RDY[2] rises the next cycle; transfer occurs the cycle after ENA.
- DEPTH=4, no responses returned, 4 issues -> inflight=4, all RDY=0; one heard delivered and a new call pending -> RDY rises the next cycle, inflight back to 4 after re-issue.
- Issues from requesters 3 then 1 -> responses delivered one-hot 4'b1000 then 4'b0010. ind$heard__RDY[3]=0 -> echo$heard__RDY=0 until it rises.
- nRST asserted with inflight=3 -> next cycle inflight=0, ptr=0, no ind$heard__ENA.

Source files
------------

// File: rtl/echo_request_arbiter_if.sv
// echo_request_arbiter_if: requester, indication and Echo-side signals of the arbiter, plus tag FIFO occupancy
interface echo_request_arbiter_if #(parameter int NREQ = 4, parameter int DEPTH = 4);
  logic [NREQ-1:0] req_say__ENA, req_say__RDY;
  logic [32*NREQ-1:0] req_say_meth, req_say_v;
  logic [NREQ-1:0] ind_heard__ENA, ind_heard__RDY;
  logic [31:0] ind_heard_meth, ind_heard_v;
  logic echo_say__ENA, echo_say__RDY, echo_heard__ENA, echo_heard__RDY;
  logic [31:0] echo_say_meth, echo_say_v, echo_heard_meth, echo_heard_v;
  logic [$clog2(DEPTH):0] inflight;
  modport slave (
    input req_say__ENA, req_say_meth, req_say_v, ind_heard__RDY,
          echo_say__RDY, echo_heard__ENA, echo_heard_meth, echo_heard_v,
    output req_say__RDY, ind_heard__ENA, ind_heard_meth, ind_heard_v,
           echo_say__ENA, echo_say_meth, echo_say_v, echo_heard__RDY, inflight
  );
  modport master (
    output req_say__ENA, req_say_meth, req_say_v, ind_heard__RDY,
           echo_say__RDY, echo_heard__ENA, echo_heard_meth, echo_heard_v,
    input req_say__RDY, ind_heard__ENA, ind_heard_meth, ind_heard_v,
          echo_say__ENA, echo_say_meth, echo_say_v, echo_heard__RDY, inflight
  );
endinterface

// File: rtl/echo_request_arbiter.sv
// echo_request_arbiter: round-robin sharing of one Echo say/heard pair, with a tag FIFO routing responses back in issue order
module echo_request_arbiter #(
  parameter int NREQ = 4,
  parameter int DEPTH = 4
) (
  input logic CLK,
  input logic nRST,
  echo_request_arbiter_if.slave bus
);
  localparam int TW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  logic [TW-1:0] ptr, ptr_nxt, head, idx;
  logic [TW-1:0] tags [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  logic [NREQ-1:0] one;
  logic full, fire, pop, found;
  assign one = NREQ'(1);
  assign full = count == (AW+1)'(DEPTH);
  assign head = tags[rd];
  assign fire = bus.req_say__ENA[ptr] && bus.echo_say__RDY && !full;
  assign bus.req_say__RDY = (bus.echo_say__RDY && !full) ? one << ptr : '0;
  assign bus.echo_say__ENA = fire;
  assign bus.echo_say_meth = bus.req_say_meth[{ptr, 5'd0} +: 32];
  assign bus.echo_say_v = bus.req_say_v[{ptr, 5'd0} +: 32];
  assign bus.echo_heard__RDY = (count != '0) && bus.ind_heard__RDY[head];
  assign pop = bus.echo_heard__ENA && bus.echo_heard__RDY;
  assign bus.ind_heard__ENA = pop ? one << head : '0;
  assign bus.ind_heard_meth = bus.echo_heard_meth;
  assign bus.ind_heard_v = bus.echo_heard_v;
  assign bus.inflight = count;
  always_comb begin
    ptr_nxt = ptr;
    found = 1'b0;
    idx = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + TW'(k);
      if (!found && bus.req_say__ENA[idx]) begin
        ptr_nxt = idx;
        found = 1'b1;
      end
    end
    if (bus.req_say__ENA[ptr] && !fire) ptr_nxt = ptr;
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      ptr <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (fire) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(fire) - (AW+1)'(pop);
    end
  always_ff @(posedge CLK)
    if (fire) tags[wr] <= ptr;
endmodule

// File: tb/tb_echo_request_arbiter.sv
// tb_echo_request_arbiter: directed vector table for the listed corner cases, then random traffic against a queue-based model
module tb_echo_request_arbiter;
  localparam int NREQ = 4;
  localparam int DEPTH = 4;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  echo_request_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus();
  echo_request_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));
  typedef struct packed {
    logic nrst;
    logic [3:0] ena, irdy;
    logic erdy, hena;
    logic [3:0] rdy;
    logic eena;
    logic [3:0] iena;
    logic hrdy;
    logic [2:0] infl;
  } vec_t;
  vec_t tbl [25];
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  int q [$];
  logic [NREQ-1:0] e_rdy, e_iena;
  logic e_fire, e_hrdy;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model_eval();
    e_rdy = (bus.echo_say__RDY && q.size() != DEPTH) ? NREQ'(1) << m_ptr : '0;
    e_fire = bus.req_say__ENA[m_ptr] && e_rdy[m_ptr];
    e_hrdy = 1'b0;
    if (q.size() != 0) e_hrdy = bus.ind_heard__RDY[q[0]];
    e_iena = '0;
    if (bus.echo_heard__ENA && e_hrdy) e_iena = NREQ'(1) << q[0];
  endfunction
  function automatic void model_update();
    int nxt;
    if (!nRST) begin
      m_ptr = 0;
      q.delete();
      return;
    end
    if (e_iena != '0) void'(q.pop_front());
    if (e_fire) q.push_back(m_ptr);
    if (bus.req_say__ENA[m_ptr] && !e_fire) return;
    nxt = m_ptr;
    for (int k = NREQ; k >= 1; k--)
      if (bus.req_say__ENA[(m_ptr + k) % NREQ]) nxt = (m_ptr + k) % NREQ;
    m_ptr = nxt;
  endfunction
  task automatic tick();
    model_eval();
    model_update();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic nrst, input logic [3:0] ena, input logic [3:0] irdy,
                       input logic erdy, input logic hena, input logic rnd);
    nRST = nrst;
    bus.req_say__ENA = ena;
    bus.ind_heard__RDY = irdy;
    bus.echo_say__RDY = erdy;
    bus.echo_heard__ENA = hena;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_say_meth[32*i +: 32] = rnd ? $urandom : 32'(i + 1);
      bus.req_say_v[32*i +: 32] = rnd ? $urandom : 32'h10 * 32'(i + 1);
    end
    bus.echo_heard_meth = $urandom;
    bus.echo_heard_v = $urandom;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 4'b0001, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 3'd1};
    tbl[2]  = '{1'b1, 4'b0100, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 4'b0100, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 3'd1};
    tbl[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1, 3'd1};
    tbl[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 3'd2};
    tbl[8]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1, 3'd3};
    tbl[9]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd4};
    tbl[10] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 3'd4};
    tbl[11] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 3'd3};
    tbl[12] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd4};
    tbl[13] = '{1'b1, 4'b0000, 4'b0111, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4};
    tbl[14] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b1, 3'd4};
    tbl[15] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0001, 1'b1, 3'd3};
    tbl[16] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0010, 1'b1, 3'd2};
    tbl[17] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0100, 1'b1, 3'd1};
    tbl[18] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 3'd0};
    tbl[19] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[20] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 3'd1};
    tbl[21] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1, 3'd2};
    tbl[22] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 3'd3};
    tbl[23] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 3'd0};
    tbl[24] = '{1'b1, 4'b0001, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0};
    drive(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].nrst, tbl[i].ena, tbl[i].irdy, tbl[i].erdy, tbl[i].hena, 1'b0);
      #3;
      chk($sformatf("v%0d say_rdy", i), bus.req_say__RDY, tbl[i].rdy);
      chk($sformatf("v%0d echo_ena", i), bus.echo_say__ENA, tbl[i].eena);
      chk($sformatf("v%0d heard_ena", i), bus.ind_heard__ENA, tbl[i].iena);
      chk($sformatf("v%0d heard_rdy", i), bus.echo_heard__RDY, tbl[i].hrdy);
      chk($sformatf("v%0d inflight", i), bus.inflight, tbl[i].infl);
      chk($sformatf("v%0d heard_v", i), bus.ind_heard_v, bus.echo_heard_v);
      tick();
    end
    drive(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(63) != 0, 4'($urandom),
            {$urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0},
            $urandom_range(3) != 0, $urandom_range(1) != 0, 1'b1);
      #3;
      model_eval();
      chk("rnd say_rdy", bus.req_say__RDY, e_rdy);
      chk("rnd echo_ena", bus.echo_say__ENA, e_fire);
      chk("rnd echo_meth", bus.echo_say_meth, bus.req_say_meth[32*m_ptr +: 32]);
      chk("rnd echo_v", bus.echo_say_v, bus.req_say_v[32*m_ptr +: 32]);
      chk("rnd heard_rdy", bus.echo_heard__RDY, e_hrdy);
      chk("rnd heard_ena", bus.ind_heard__ENA, e_iena);
      chk("rnd heard_meth", bus.ind_heard_meth, bus.echo_heard_meth);
      chk("rnd inflight", bus.inflight, 64'(q.size()));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
